// File: rtl/preg_alloc_ctrl_pkg.sv
// Shared definitions for the physical-register free-list allocator.
//   DEF_NUM_PREGS / DEF_TAG_W / DEF_BASE_TAG : parameter defaults
//   preg_state_e                             : controller state {NORMAL, RECOVER}
package preg_pkg;

   localparam int unsigned DEF_NUM_PREGS = 32;
   localparam int unsigned DEF_TAG_W     = 6;
   localparam int unsigned DEF_BASE_TAG  = 32;

   typedef enum logic [0:0] {
      NORMAL  = 1'b0,
      RECOVER = 1'b1
   } preg_state_e;

endpackage

// File: rtl/preg_alloc_ctrl_if.sv
// Rename-side bus of the free-list allocator.
//   master : rename/retire/ROB side (drives req, free_*, flush, reclaim_*)
//   slave  : allocator (drives grant, tag0/1, busy, count, ovf)
interface preg_alloc_ctrl_if
   import preg_pkg::*;
#(
   parameter int unsigned NUM_PREGS = DEF_NUM_PREGS,
   parameter int unsigned TAG_W     = DEF_TAG_W
);
   localparam int unsigned CNT_W = $clog2(NUM_PREGS + 1);

   logic [1:0]       req;
   logic [1:0]       grant;
   logic [TAG_W-1:0] tag0;
   logic [TAG_W-1:0] tag1;
   logic             free_valid;
   logic [TAG_W-1:0] free_tag;
   logic             flush;
   logic             reclaim_valid;
   logic [TAG_W-1:0] reclaim_tag;
   logic             reclaim_done;
   logic             busy;
   logic [CNT_W-1:0] count;
   logic             ovf;

   modport master (
      output req, free_valid, free_tag, flush, reclaim_valid, reclaim_tag, reclaim_done,
      input  grant, tag0, tag1, busy, count, ovf
   );

   modport slave (
      input  req, free_valid, free_tag, flush, reclaim_valid, reclaim_tag, reclaim_done,
      output grant, tag0, tag1, busy, count, ovf
   );

endinterface

// File: rtl/preg_alloc_ctrl_ring.sv
// Free-list tag storage: NUM_PREGS entries, 2 async read ports, 2 write ports.
//   clk, reset          : clock, async active-high reset (loads BASE_TAG+i)
//   rd0/rd1_idx, _data  : read ports
//   wr0/wr1_en/idx/data : write ports (wr1 wins on equal index; never used that way)
module preg_ring
   import preg_pkg::*;
#(
   parameter int unsigned NUM_PREGS = DEF_NUM_PREGS,
   parameter int unsigned TAG_W     = DEF_TAG_W,
   parameter int unsigned BASE_TAG  = DEF_BASE_TAG,
   localparam int unsigned PTR_W    = $clog2(NUM_PREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PTR_W-1:0] rd0_idx,
   input  logic [PTR_W-1:0] rd1_idx,
   output logic [TAG_W-1:0] rd0_data,
   output logic [TAG_W-1:0] rd1_data,
   input  logic             wr0_en,
   input  logic [PTR_W-1:0] wr0_idx,
   input  logic [TAG_W-1:0] wr0_data,
   input  logic             wr1_en,
   input  logic [PTR_W-1:0] wr1_idx,
   input  logic [TAG_W-1:0] wr1_data
);

   logic [TAG_W-1:0] mem [NUM_PREGS];

   // Storage array; reset fills it with consecutive tags starting at BASE_TAG.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            mem[i] <= TAG_W'(BASE_TAG + i);
         end
      end else begin
         if (wr0_en) mem[wr0_idx] <= wr0_data;
         if (wr1_en) mem[wr1_idx] <= wr1_data;
      end
   end

   assign rd0_data = mem[rd0_idx];
   assign rd1_data = mem[rd1_idx];

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Physical-register free-list allocator with flush recovery.
//   clk, reset : clock, async active-high reset
//   bus        : preg_alloc_ctrl_if.slave (req/grant/tags, frees, flush, reclaims,
//                busy, count, ovf)
//   stall_cnt, recover_cnt : saturating statistics, only with PREG_ALLOC_STATS_EN
module preg_alloc_ctrl
   import preg_pkg::*;
#(
   parameter int unsigned NUM_PREGS = DEF_NUM_PREGS,
   parameter int unsigned TAG_W     = DEF_TAG_W,
   parameter int unsigned BASE_TAG  = DEF_BASE_TAG
) (
   input  logic               clk,
   input  logic               reset,
   preg_alloc_ctrl_if.slave   bus
`ifdef PREG_ALLOC_STATS_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        recover_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(NUM_PREGS);
   localparam int unsigned CNT_W = $clog2(NUM_PREGS + 1);
   localparam int unsigned RM_W  = CNT_W + 1;

   // Circular pointer advance by 0..2 with wrap at NUM_PREGS.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [1:0] n);
      logic [PTR_W:0] s;
      s = {1'b0, p} + (PTR_W+1)'(n);
      if (s >= (PTR_W+1)'(NUM_PREGS)) s = s - (PTR_W+1)'(NUM_PREGS);
      return s[PTR_W-1:0];
   endfunction

   preg_state_e      state_q, state_d;
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q;

   logic [1:0]       grant_c;
   logic [1:0]       pops, pushes;
   logic [RM_W-1:0]  room;
   logic             free_acc, rec_try, rec_acc, drop;
   logic             wr0_en, wr1_en;
   logic [TAG_W-1:0] wr0_data;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= NORMAL;
      else       state_q <= state_d;
   end

   // Next state: a flush always lands in (or holds) RECOVER.
   always_comb begin
      state_d = state_q;
      case (state_q)
         NORMAL:  if (bus.flush) state_d = RECOVER;
         RECOVER: if (!bus.flush && bus.reclaim_done) state_d = NORMAL;
         default: state_d = NORMAL;
      endcase
   end

   // Grants, push acceptance and overflow detection. Room counts slots freed by
   // this cycle's pops, since the ring write lands at tail on the same edge.
   always_comb begin
      grant_c[0] = bus.req[0] & (state_q == NORMAL) & ~bus.flush & (count_q >= CNT_W'(1));
      grant_c[1] = bus.req[1] & grant_c[0] & (count_q >= CNT_W'(2));
      pops       = 2'(grant_c[0]) + 2'(grant_c[1]);
      room       = RM_W'(NUM_PREGS) - RM_W'(count_q) + RM_W'(pops);
      free_acc   = bus.free_valid & (room >= RM_W'(1));
      rec_try    = bus.reclaim_valid & (state_q == RECOVER);
      rec_acc    = rec_try & (room >= RM_W'(1) + RM_W'(free_acc));
      drop       = (bus.free_valid & ~free_acc) | (rec_try & ~rec_acc);
      pushes     = 2'(free_acc) + 2'(rec_acc);
      wr0_en     = free_acc | rec_acc;
      wr1_en     = free_acc & rec_acc;
      wr0_data   = free_acc ? bus.free_tag : bus.reclaim_tag;
      count_d    = count_q - CNT_W'(pops) + CNT_W'(pushes);
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_W'(NUM_PREGS);
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= ptr_add(head_q, pops);
         tail_q  <= ptr_add(tail_q, pushes);
         count_q <= count_d;
         ovf_q   <= ovf_q | drop;
      end
   end

   preg_ring #(
      .NUM_PREGS (NUM_PREGS),
      .TAG_W     (TAG_W),
      .BASE_TAG  (BASE_TAG)
   ) u_ring (
      .clk      (clk),
      .reset    (reset),
      .rd0_idx  (head_q),
      .rd1_idx  (ptr_add(head_q, 2'd1)),
      .rd0_data (bus.tag0),
      .rd1_data (bus.tag1),
      .wr0_en   (wr0_en),
      .wr0_idx  (tail_q),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_idx  (ptr_add(tail_q, 2'd1)),
      .wr1_data (bus.reclaim_tag)
   );

   assign bus.grant = grant_c;
   assign bus.busy  = (state_q == RECOVER);
   assign bus.count = count_q;
   assign bus.ovf   = ovf_q;

`ifdef PREG_ALLOC_STATS_EN
   // Saturating stall and recovery-cycle counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt   <= '0;
         recover_cnt <= '0;
      end else begin
         if (bus.req[0] && !grant_c[0] && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
         if ((state_q == RECOVER) && (recover_cnt != '1))    recover_cnt <= recover_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed bench for preg_alloc_ctrl with a free-list FIFO scoreboard.
module tb_preg_alloc_ctrl;
   import preg_pkg::*;

   localparam int unsigned N  = 32;
   localparam int unsigned TW = 6;
   localparam int unsigned BT = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   preg_alloc_ctrl_if #(.NUM_PREGS(N), .TAG_W(TW)) bus ();

`ifdef PREG_ALLOC_STATS_EN
   logic [31:0] stall_cnt, recover_cnt;
`endif

   preg_alloc_ctrl #(.NUM_PREGS(N), .TAG_W(TW), .BASE_TAG(BT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef PREG_ALLOC_STATS_EN
      ,
      .stall_cnt   (stall_cnt),
      .recover_cnt (recover_cnt)
`endif
   );

   int ncmp = 0;
   int nerr = 0;

   // Scoreboard: tags expected out of the free list, in FIFO order.
   logic [TW-1:0] mq[$];
   bit            mrec;
   bit            movf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic idle_inputs();
      bus.req = 2'b00; bus.flush = 1'b0;
      bus.free_valid = 1'b0; bus.free_tag = '0;
      bus.reclaim_valid = 1'b0; bus.reclaim_tag = '0; bus.reclaim_done = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < N; i++) mq.push_back(TW'(BT + i));
      mrec = 1'b0;
      movf = 1'b0;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "/count"}, 32'(bus.count), 32'(mq.size()));
      chk({tag, "/busy"},  32'(bus.busy),  32'(mrec));
      chk({tag, "/ovf"},   32'(bus.ovf),   32'(movf));
      if (mq.size() > 0) chk({tag, "/head"}, 32'(bus.tag0), 32'(mq[0]));
   endtask

   // Asserted at a negedge; checks async clear, then releases and rechecks.
   task automatic do_reset(input string tag);
      idle_inputs();
      reset = 1'b1;
      model_reset();
      #1;
      chk({tag, "/in_reset/grant"}, 32'(bus.grant), 32'd0);
      chk_state({tag, "/in_reset"});
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_state({tag, "/released"});
   endtask

   // One cycle: drive at negedge, check grants/tags, update model, check after edge.
   task automatic step(input logic [1:0] r, input logic fl,
                       input logic fv, input logic [TW-1:0] ft,
                       input logic rv, input logic [TW-1:0] rt, input logic rd,
                       input string tag);
      int          sz;
      bit          g0, g1;
      logic [TW-1:0] e;
      bus.req = r; bus.flush = fl;
      bus.free_valid = fv; bus.free_tag = ft;
      bus.reclaim_valid = rv; bus.reclaim_tag = rt; bus.reclaim_done = rd;
      #1;
      sz = mq.size();
      g0 = r[0] && !mrec && !fl && (sz >= 1);
      g1 = r[1] && g0 && (sz >= 2);
      chk({tag, "/grant"}, 32'(bus.grant), {30'd0, g1, g0});
      if (g0) begin
         e = mq.pop_front();
         chk({tag, "/tag0"}, 32'(bus.tag0), 32'(e));
      end
      if (g1) begin
         e = mq.pop_front();
         chk({tag, "/tag1"}, 32'(bus.tag1), 32'(e));
      end
      if (fv) begin
         if (mq.size() < N) mq.push_back(ft);
         else movf = 1'b1;
      end
      if (rv && mrec) begin
         if (mq.size() < N) mq.push_back(rt);
         else movf = 1'b1;
      end
      if (!mrec) mrec = fl;
      else if (!fl && rd) mrec = 1'b0;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      chk_state(tag);
   endtask

   initial begin
      idle_inputs();
      @(negedge clk);
      do_reset("reset0");

      // Dual allocation straight out of reset.
      step(2'b11, 0, 0, 0, 0, 0, 0, "alloc2");
      repeat (14) step(2'b11, 0, 0, 0, 0, 0, 0, "drain");
      step(2'b01, 0, 0, 0, 0, 0, 0, "drain1");
      // Only one tag left: slot 1 must not be granted.
      step(2'b11, 0, 0, 0, 0, 0, 0, "last1");
      // Empty list: same-cycle free does not enable a grant.
      step(2'b01, 0, 1, 6'd40, 0, 0, 0, "empty_free");

      // Flush beats requests; reclaims during recovery.
      step(2'b11, 1, 0, 0, 0, 0, 0, "flush");
      step(2'b01, 0, 0, 0, 1, 6'd50, 0, "rec50");
      step(2'b00, 1, 0, 0, 1, 6'd51, 1, "rec51_flush_hold");
      step(2'b00, 0, 0, 0, 1, 6'd52, 1, "rec52_done");
      step(2'b00, 0, 0, 0, 1, 6'd7,  0, "rec_in_normal");

      // Fill to capacity, then overflow.
      for (int i = 0; i < 28; i++) step(2'b00, 0, 1, TW'(i), 0, 0, 0, "fill");
      step(2'b00, 0, 1, 6'd9, 0, 0, 0, "ovf");
      step(2'b00, 0, 0, 0, 0, 0, 0, "ovf_sticky");

      // Interleaved alloc/free across the pointer wrap.
      for (int i = 0; i < 48; i++) begin
         step((i % 3 == 0) ? 2'b11 : 2'b01, 0, 1, TW'(i + 10), 0, 0, 0, "wrap");
      end

      // Free and reclaim in one recovery cycle: free goes first.
      step(2'b00, 1, 0, 0, 0, 0, 0, "flush2");
      step(2'b00, 0, 1, 6'd60, 1, 6'd61, 1, "dual_push");
      repeat (10) step(2'b11, 0, 0, 0, 0, 0, 0, "drain_order");

      // Reset in the middle of recovery.
      step(2'b00, 1, 0, 0, 0, 0, 0, "flush3");
      step(2'b01, 0, 0, 0, 1, 6'd5, 0, "rec_mid");
      do_reset("reset_mid_recover");
      step(2'b11, 0, 0, 0, 0, 0, 0, "alloc_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
